lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit LFSR pattern generator. It accepts the generator's successive 8-bit states, locks onto the sequence, and flywheels a local prediction once locked. It counts every sample that departs from the sequence and shows the low byte of that count on two active-low seven-segment digits. It sits between the pattern source (or a loopback path) and the board displays, and serves as a self-check for the generator.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/seg7_hex.sv | 11 +
 rtl/lfsr_checker.sv | 135 +++++++++++++
 tb/tb_lfsr_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and its checker:
// tap set, next-state function, checker FSM states and hex glyph table.
package lfsr_pkg;

  // Feedback taps are bits 7,5,4,3; feedback enters at bit 7 on a right shift.
  localparam logic [7:0] TAP_MASK = 8'hB8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Hex glyphs, active-high, bit7..0 = a,b,c,d,e,f,g,dp; index 0 is the LSB entry.
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {^(x & TAP_MASK), x[7:1]};
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex nibble to active-low seven-segment pattern, decimal point held off.
module seg7_hex
  import lfsr_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg_n
);

  assign seg_n = ~SEG_GLYPH[hex];

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto an observed LFSR state stream, flywheels a local prediction once
// locked, and counts mismatched samples onto two seven-segment digits.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_CNT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  state_t             state_q, state_d;
  logic [7:0]         pred_q, pred_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               match;
  logic [RUN_W-1:0]   run_inc;
  logic [MISS_W-1:0]  miss_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    match       = (in_data == pred_q);
    run_inc     = run_q + 1'b1;
    miss_inc    = miss_q + 1'b1;

    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          // 0x00 is the lockup state and can never seed the prediction.
          if (in_data != 8'h00) begin
            pred_d  = nxt(in_data);
            run_d   = RUN_ONE;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            pred_d = nxt(in_data);
            run_d  = run_inc;
            if (run_inc == RUN_LOCK) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (in_data != 8'h00) begin
            pred_d = nxt(in_data);
            run_d  = RUN_ONE;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: once locked the prediction only ever follows itself.
          pred_d = nxt(pred_q);
          if (match) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
            miss_d      = miss_inc;
            if (miss_inc == MISS_LOSS) state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (clr_err) err_cnt_d = '0;
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      pred_q      <= 8'h00;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

  seg7_hex u_seg0 (
    .hex   (err_cnt_q[3:0]),
    .seg_n (seg0)
  );

  seg7_hex u_seg1 (
    .hex   (err_cnt_q[7:4]),
    .seg_n (seg1)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table, async reset, randomized
// stream against a behavioural model, and a saturating 8-bit counter instance.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr_err = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [7:0]  seg0, seg1;

  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_clr = 1'b0;
  logic        s_locked, s_pulse;
  logic [7:0]  s_err;
  logic [7:0]  s_seg0, s_seg1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .seg0(seg0), .seg1(seg1)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(255), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .clr_err(s_clr),
    .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_err), .seg0(s_seg0), .seg1(s_seg1)
  );

  logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  function automatic int ref_nxt(input int x);
    int fb;
    fb = $countones(x & 'hB8) % 2;
    return ((x >> 1) | (fb << 7)) & 'hFF;
  endfunction

  function automatic int seg_of(input int nib);
    logic [7:0] g;
    g = ~glyph[nib & 15];
    return int'(g);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    @(negedge clk);
    in_valid = v; in_data = d; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic s_step(input bit v, input logic [7:0] d, input bit c);
    @(negedge clk);
    s_valid = v; s_data = d; s_clr = c;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: mode 0 hunting, 1 verifying, 2 locked.
  int m_mode, m_pred, m_run, m_miss, m_err;
  bit m_pulse;

  task automatic model_reset();
    m_mode = 0; m_pred = 0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit hit;
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = ref_nxt(d); m_run = 1; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_pred = ref_nxt(d);
          m_run++;
          if (m_run == 4) begin m_mode = 2; m_miss = 0; end
        end else if (d != 0) begin
          m_pred = ref_nxt(d); m_run = 1;
        end else begin
          m_mode = 0;
        end
      end else begin
        hit = (d == m_pred);
        m_pred = ref_nxt(m_pred);
        if (hit) m_miss = 0;
        else begin
          m_pulse = 1;
          if (m_err < 65535) m_err++;
          m_miss++;
          if (m_miss == 3) m_mode = 0;
        end
      end
    end
    if (c) m_err = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " locked"}, int'(locked), (m_mode == 2) ? 1 : 0);
    chk({tag, " err_pulse"}, int'(err_pulse), int'(m_pulse));
    chk({tag, " err_cnt"}, int'(err_cnt), m_err);
    chk({tag, " seg0"}, int'(seg0), seg_of(m_err));
    chk({tag, " seg1"}, int'(seg1), seg_of(m_err >> 4));
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         c;
    bit         e_lock;
    bit         e_pulse;
    int         e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int src, r, d, sp;
    bit v, c;

    // Reset state, sampled while rst is held low.
    #12;
    chk("rst locked", int'(locked), 0);
    chk("rst err_pulse", int'(err_pulse), 0);
    chk("rst err_cnt", int'(err_cnt), 0);
    chk("rst seg0", int'(seg0), 'h03);
    chk("rst seg1", int'(seg1), 'h03);
    @(negedge clk);
    rst = 1'b1;

    // Directed sequence: lockup, lock, single error, loss, VERIFY->HUNT, relock, clear.
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h90, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 3});
    tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 4});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 4});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h91, 1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d locked", i), int'(locked), int'(tbl[i].e_lock));
      chk($sformatf("vec%0d err_pulse", i), int'(err_pulse), int'(tbl[i].e_pulse));
      chk($sformatf("vec%0d err_cnt", i), int'(err_cnt), tbl[i].e_err);
      chk($sformatf("vec%0d seg0", i), int'(seg0), seg_of(tbl[i].e_err));
      chk($sformatf("vec%0d seg1", i), int'(seg1), seg_of(tbl[i].e_err >> 4));
    end
    chk("single err seg0", int'(tbl[6].e_err == 1 ? 8'h9F : 8'h00), seg_of(1));

    // Asynchronous reset mid-lock, observed before the next clock edge.
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst locked", int'(locked), 0);
    chk("async rst err_cnt", int'(err_cnt), 0);
    chk("async rst seg0", int'(seg0), 'h03);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h44, 1'b0);
    chk("after rst no lock", int'(locked), 0);

    // Randomized stream against the reference model.
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    src = 'h11;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      v = (r >= 10);
      c = ($urandom_range(0, 59) == 0);
      d = 0;
      if (v) begin
        if (src == 0 || $urandom_range(0, 99) < 2) src = $urandom_range(1, 255);
        r = $urandom_range(0, 99);
        if (r < 82) d = src;
        else if (r < 88) d = 0;
        else d = $urandom_range(0, 255);
        src = ref_nxt(src);
      end
      step(v, 8'(d), c);
      model_step(v, d, c);
      check_model($sformatf("rnd%0d", i));
    end
    step(1'b0, 8'h00, 1'b0);

    // 8-bit counter instance: clear beats increment, then saturation.
    s_step(1'b1, 8'h11, 1'b0);
    s_step(1'b1, 8'h88, 1'b0);
    s_step(1'b1, 8'h44, 1'b0);
    s_step(1'b1, 8'h22, 1'b0);
    chk("sat locked", int'(s_locked), 1);
    sp = ref_nxt('h22);
    s_step(1'b1, 8'(sp ^ 1), 1'b0);
    chk("sat first err", int'(s_err), 1);
    sp = ref_nxt(sp);
    s_step(1'b1, 8'(sp ^ 1), 1'b1);
    chk("clr+err err_cnt", int'(s_err), 0);
    chk("clr+err err_pulse", int'(s_pulse), 1);
    sp = ref_nxt(sp);
    for (int i = 0; i < 300; i++) begin
      s_step(1'b1, 8'((i % 50 == 25) ? sp : (sp ^ 1)), 1'b0);
      sp = ref_nxt(sp);
    end
    chk("sat err_cnt", int'(s_err), 'hFF);
    chk("sat seg0", int'(s_seg0), 'h71);
    chk("sat seg1", int'(s_seg1), 'h71);
    chk("sat still locked", int'(s_locked), 1);
    chk("sat last pulse", int'(s_pulse), 1);
    s_step(1'b0, 8'h00, 1'b0);
    chk("sat pulse one cycle", int'(s_pulse), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
